// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline and pipeline_hazard_ctrl.
// The pipeline side (master) reports the ID/EX instruction fields it sees.
// The controller side (slave) returns stall/flush/bubble controls and the mul/div sequencing.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // instruction information from ID and EX
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_md_op;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_redirect;

  // pipeline controls back to the datapath
  logic             pc_en;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             md_start;
  logic             md_abort;
  logic             md_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md_op,
    output ex_mem_read, ex_rd, ex_redirect,
    input  pc_en, ifid_stall, ifid_flush, idex_flush,
    input  md_start, md_abort, md_busy, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_op,
    input  ex_mem_read, ex_rd, ex_redirect,
    output pc_en, ifid_stall, ifid_flush, idex_flush,
    output md_start, md_abort, md_busy, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Detects load-use hazards, applies EX-stage redirects, sequences the fixed-latency
// mul/div unit (RUN -> MD_WAIT -> MD_DONE) and keeps a saturating stall-cycle count.
// Control outputs are combinational from state and inputs; the pipeline registers
// sample them on the falling edge, half a cycle after the state update.
module pipeline_hazard_ctrl #(
  parameter int MD_CYCLES = 8,
  parameter int CNT_W     = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  // Wait-counter load value: MD_CYCLES-1 wait cycles follow the start cycle,
  // so the single MD_DONE cycle lands exactly MD_CYCLES cycles after MD_Start.
  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MD_WAIT = 2'b01,
    MD_DONE = 2'b10
  } state_t;

  state_t           state;
  logic [7:0]       cnt;
  logic [CNT_W-1:0] stall_count;

  logic lu;
  logic rs_hit;
  logic rt_hit;

  logic pc_en;
  logic ifid_stall;
  logic ifid_flush;
  logic idex_flush;
  logic md_start;
  logic md_abort;
  logic md_busy;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Load-use hazard: EX load writes a non-zero register that ID reads.
  assign rs_hit = bus.id_use_rs && (bus.id_rs == bus.ex_rd);
  assign rt_hit = bus.id_use_rt && (bus.id_rt == bus.ex_rd);
  assign lu     = bus.ex_mem_read && (bus.ex_rd != 5'd0) && (rs_hit || rt_hit);

  // Combinational control decode from current state and inputs.
  always_comb begin
    pc_en      = 1'b1;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    md_start   = 1'b0;
    md_abort   = 1'b0;
    md_busy    = 1'b0;
    if (rst) begin
      // Hold the front end empty while in reset.
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (bus.ex_redirect) begin
            // Redirect wins: squash the wrong-path instructions in IF/ID and ID.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (lu) begin
            // One bubble lets the load reach MEM so the value can be forwarded.
            pc_en      = 1'b0;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end else if (bus.id_md_op) begin
            // Launch mul/div; hold the instruction in ID until its result is ready.
            md_start   = 1'b1;
            pc_en      = 1'b0;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          md_busy = 1'b1;
          if (bus.ex_redirect) begin
            // Should not happen while the front end is frozen; cancel and recover.
            md_abort   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else begin
            pc_en      = 1'b0;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MD_DONE: begin
          // Everything at default: the mul/div instruction advances with its result.
        end
        default: begin
          // Unused encoding: behave as default outputs, FSM returns to RUN.
        end
      endcase
    end
  end

  // State, wait counter and stall statistics update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= 8'd0;
      stall_count <= '0;
    end else begin
      if (!pc_en) begin
        stall_count <= sat_inc(stall_count);
      end
      case (state)
        RUN: begin
          if (!bus.ex_redirect && !lu && bus.id_md_op) begin
            cnt   <= MD_LOAD;
            state <= MD_WAIT;
          end
        end
        MD_WAIT: begin
          cnt <= cnt - 8'd1;
          if (bus.ex_redirect) begin
            state <= RUN;
          end else if (cnt == 8'd1) begin
            state <= MD_DONE;
          end
        end
        MD_DONE: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_stall  = ifid_stall;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.md_start    = md_start;
  assign bus.md_abort    = md_abort;
  assign bus.md_busy     = md_busy;
  assign bus.stall_count = stall_count;

endmodule
